// File: rtl/shift_capture_pkg.sv
// Shared types and constants for the shift-register word capture block.
package shift_capture_pkg;

  // Word-assembly state: nothing in progress, partial word, word complete.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    CAPT = 2'd2
  } cap_state_t;

  // Shift direction as driven into the monitored shift register.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Width of the optional statistics counters.
  localparam int STAT_W = 16;

endpackage

// File: rtl/shift_capture_fifo.sv
// Small synchronous FIFO for captured words. The head entry is presented
// through registers, so a pushed word becomes visible one clock after the
// push. Pushing into a full FIFO without a simultaneous pop drops the word
// and raises the combinational drop flag for that cycle.
module shift_capture_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         ready,
  output logic [W-1:0]                 head_data,
  output logic                         head_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_sel;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic [CNT_W-1:0] cnt_after_pop;

  // A pop frees a slot in the same cycle, so full+push+pop still writes.
  assign pop           = head_valid & ready;
  assign full          = (count == CNT_W'(DEPTH));
  assign wr_en         = push & (~full | pop);
  assign drop          = push & full & ~pop;
  assign cnt_after_pop = count - CNT_W'(pop);
  // Pointers wrap naturally because DEPTH is a power of two.
  assign rd_sel        = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

  // Storage write port.
  // NOTE: the storage array has no reset; validity is tracked by count and
  // head_valid, so stale contents are never observed and the array can map
  // onto plain flops or distributed RAM without a reset network.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and the registered head entry.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr     <= rd_sel;
      count      <= cnt_after_pop + CNT_W'(wr_en);
      head_valid <= (cnt_after_pop != '0);
      if (cnt_after_pop != '0) head_data <= mem[rd_sel];
    end
  end

endmodule

// File: rtl/shift_word_capture.sv
// Monitors the enable/direction controls and parallel output of a shift
// register, counts shifts in one direction and, once WIDTH shifts have
// completed, queues the parallel word (with its direction) for a
// valid/ready consumer. A direction change mid-word discards the partial
// word; sync_clr restarts counting without touching queued words.
// Optional: define SHIFT_WORD_CAPTURE_STATS_EN to add saturating
// words_cnt/drops_cnt statistics outputs.
module shift_word_capture
  import shift_capture_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sr_enable,
  input  logic                       sr_drive,
  input  logic [WIDTH-1:0]           sr_out,
  input  logic                       sync_clr,
  output logic [WIDTH-1:0]           word_data,
  output logic                       word_dir,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic                       drop_pulse,
  output logic                       abort_pulse,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt
`ifdef SHIFT_WORD_CAPTURE_STATS_EN
  ,
  output logic [STAT_W-1:0]          words_cnt,
  output logic [STAT_W-1:0]          drops_cnt
`endif
);

  localparam int CNT_W = $clog2(WIDTH+1);

  cap_state_t       state;
  cap_state_t       state_d;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             cur_dir;
  logic             dir_d;
  logic             abort_d;
  logic             restart;
  logic             push;
  logic             fifo_drop;
  logic [WIDTH:0]   head;

  // Next word-count state. A shift that starts a new word (from IDLE, from
  // CAPT, or against the current direction) counts as bit 1.
  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    cnt_d   = bit_cnt;
    dir_d   = cur_dir;
    abort_d = 1'b0;
    restart = (state != FILL) || (sr_drive != cur_dir);
    cnt_inc = restart ? CNT_W'(1) : bit_cnt + CNT_W'(1);
    if (sync_clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (sr_enable) begin
      abort_d = (state == FILL) && (sr_drive != cur_dir);
      dir_d   = restart ? sr_drive : cur_dir;
      if (cnt_inc == CNT_W'(WIDTH)) begin
        cnt_d   = '0;
        state_d = CAPT;
      end else begin
        cnt_d   = cnt_inc;
        state_d = FILL;
      end
    end else if (state == CAPT) begin
      state_d = IDLE;
    end
  end

  // Word-count registers and the abort/drop pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      cur_dir     <= DIR_LEFT;
      abort_pulse <= 1'b0;
      drop_pulse  <= 1'b0;
    end else begin
      state       <= state_d;
      bit_cnt     <= cnt_d;
      cur_dir     <= dir_d;
      abort_pulse <= abort_d;
      drop_pulse  <= fifo_drop;
    end
  end

  // In CAPT, sr_out already holds the word produced by the final shift.
  assign push = (state == CAPT) && !sync_clr;

  shift_capture_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  ({cur_dir, sr_out}),
    .ready      (word_ready),
    .head_data  (head),
    .head_valid (word_valid),
    .count      (fill_cnt),
    .drop       (fifo_drop)
  );

  assign word_dir  = head[WIDTH];
  assign word_data = head[WIDTH-1:0];

`ifdef SHIFT_WORD_CAPTURE_STATS_EN
  // Saturating counts of accepted words and dropped words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_cnt <= '0;
      drops_cnt <= '0;
    end else if (sync_clr) begin
      words_cnt <= '0;
      drops_cnt <= '0;
    end else begin
      if (push && !fifo_drop && (words_cnt != '1)) words_cnt <= words_cnt + 1'b1;
      if (fifo_drop && (drops_cnt != '1))          drops_cnt <= drops_cnt + 1'b1;
    end
  end
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_shift_word_capture.sv
// Self-checking bench for shift_word_capture: directed scenarios with
// literal expectations plus a randomized run compared every cycle against
// a queue-based behavioural model.
module tb_shift_word_capture;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int FW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sr_enable = 1'b0;
  logic          sr_drive = 1'b0;
  logic [W-1:0]  sr_out = '0;
  logic          sync_clr = 1'b0;
  logic          word_ready = 1'b0;
  logic [W-1:0]  word_data;
  logic          word_dir;
  logic          word_valid;
  logic          drop_pulse;
  logic          abort_pulse;
  logic [FW-1:0] fill_cnt;
`ifdef SHIFT_WORD_CAPTURE_STATS_EN
  logic [15:0]   words_cnt;
  logic [15:0]   drops_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_word_capture #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sr_enable   (sr_enable),
    .sr_drive    (sr_drive),
    .sr_out      (sr_out),
    .sync_clr    (sync_clr),
    .word_data   (word_data),
    .word_dir    (word_dir),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .drop_pulse  (drop_pulse),
    .abort_pulse (abort_pulse),
    .fill_cnt    (fill_cnt)
`ifdef SHIFT_WORD_CAPTURE_STATS_EN
    ,
    .words_cnt   (words_cnt),
    .drops_cnt   (drops_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // run_len counts consecutive same-direction shifts of the word in
  // progress; a completed word is sampled from sr_out one edge later and
  // appended to a queue; a queued word shows at the head one edge after it
  // is queued.
  int           run_len;
  bit           run_dir;
  bit           pending;
  logic [W:0]   q[$];
  bit           m_valid;
  logic [W:0]   m_head;
  bit           m_drop;
  bit           m_abort;
  int           m_fill;
  int           m_words;
  int           m_drops;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_len = 0; run_dir = 0; pending = 0; q.delete();
      m_valid = 0; m_head = '0; m_drop = 0; m_abort = 0; m_fill = 0;
      m_words = 0; m_drops = 0;
    end else begin
      bit pop, was_full;
      pop      = m_valid && word_ready;
      was_full = (q.size() == D);
      if (pop) void'(q.pop_front());
      m_valid = (q.size() > 0);
      if (m_valid) m_head = q[0];
      m_drop  = 0;
      m_abort = 0;
      if (pending && !sync_clr) begin
        if (was_full && !pop) begin
          m_drop = 1;
          if (m_drops < 65535) m_drops++;
        end else begin
          q.push_back({run_dir, sr_out});
          if (m_words < 65535) m_words++;
        end
      end
      pending = 0;
      if (sync_clr) begin
        run_len = 0; m_words = 0; m_drops = 0;
      end else if (sr_enable) begin
        if (run_len == 0) begin
          run_dir = sr_drive; run_len = 1;
        end else if (sr_drive != run_dir) begin
          m_abort = 1; run_dir = sr_drive; run_len = 1;
        end else begin
          run_len++;
        end
        if (run_len == W) begin
          run_len = 0; pending = 1;
        end
      end
      m_fill = q.size();
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_valid", {31'd0, word_valid}, {31'd0, m_valid});
      check("cyc_fill", 32'(fill_cnt), 32'(m_fill));
      check("cyc_drop", {31'd0, drop_pulse}, {31'd0, m_drop});
      check("cyc_abort", {31'd0, abort_pulse}, {31'd0, m_abort});
      if (m_valid) begin
        check("cyc_data", 32'(word_data), 32'(m_head[W-1:0]));
        check("cyc_dir", {31'd0, word_dir}, {31'd0, m_head[W]});
      end
`ifdef SHIFT_WORD_CAPTURE_STATS_EN
      check("cyc_words", 32'(words_cnt), 32'(m_words));
      check("cyc_drops", 32'(drops_cnt), 32'(m_drops));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit en, input bit drv, input bit clr, input bit rdy,
                     input logic [W-1:0] sr_after);
    sr_enable  = en;
    sr_drive   = drv;
    sync_clr   = clr;
    word_ready = rdy;
    @(posedge clk);
    #1;
    if (en) sr_out = sr_after;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, rdy, '0);
  endtask

  task automatic shifts(input int n, input bit drv, input logic [W-1:0] last);
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] v;
      v = (i == n - 1) ? last : W'($urandom);
      cyc(1'b1, drv, 1'b0, 1'b0, v);
    end
  endtask

  initial begin
    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, word_valid}, 32'd0);
    check("rst_fill", 32'(fill_cnt), 32'd0);
    check("rst_data", 32'(word_data), 32'd0);
    check("rst_dir", {31'd0, word_dir}, 32'd0);
    check("rst_drop", {31'd0, drop_pulse}, 32'd0);
    check("rst_abort", {31'd0, abort_pulse}, 32'd0);
    rst_n = 1'b1;
    idle(1, 1'b0);

    // Single word: valid exactly two edges after the 8th shift.
    shifts(8, 1'b0, 8'hAA);
    check("t1_valid_e0", {31'd0, word_valid}, 32'd0);
    idle(1, 1'b0);
    check("t1_valid_e1", {31'd0, word_valid}, 32'd0);
    idle(1, 1'b0);
    check("t1_valid_e2", {31'd0, word_valid}, 32'd1);
    check("t1_data", 32'(word_data), 32'hAA);
    check("t1_dir", {31'd0, word_dir}, 32'd0);
    idle(1, 1'b1);
    check("t1_popped", {31'd0, word_valid}, 32'd0);

    // Back-to-back words, right direction.
    shifts(8, 1'b1, 8'h55);
    shifts(8, 1'b1, 8'h0F);
    idle(3, 1'b0);
    check("t2_fill", 32'(fill_cnt), 32'd2);
    check("t2_head0", 32'(word_data), 32'h55);
    check("t2_dir0", {31'd0, word_dir}, 32'd1);
    idle(1, 1'b1);
    check("t2_head1", 32'(word_data), 32'h0F);
    check("t2_dir1", {31'd0, word_dir}, 32'd1);
    idle(1, 1'b1);
    check("t2_empty", 32'(fill_cnt), 32'd0);

    // Overflow: third word dropped while full.
    shifts(8, 1'b0, 8'h11);
    shifts(8, 1'b0, 8'h22);
    shifts(8, 1'b0, 8'h33);
    idle(1, 1'b0);
    check("t3_drop", {31'd0, drop_pulse}, 32'd1);
    check("t3_fill", 32'(fill_cnt), 32'd2);
    idle(1, 1'b0);
    check("t3_drop_once", {31'd0, drop_pulse}, 32'd0);
    check("t3_head", 32'(word_data), 32'h11);
    // Full with simultaneous pop: the new word becomes the tail.
    shifts(8, 1'b0, 8'h44);
    idle(1, 1'b1);
    check("t3b_nodrop", {31'd0, drop_pulse}, 32'd0);
    check("t3b_fill", 32'(fill_cnt), 32'd2);
    check("t3b_head", 32'(word_data), 32'h22);
    idle(1, 1'b1);
    check("t3b_tail", 32'(word_data), 32'h44);
    idle(2, 1'b1);
    check("t3b_empty", 32'(fill_cnt), 32'd0);

    // Direction change discards the partial word.
    shifts(5, 1'b0, 8'h01);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h02);
    check("t4_abort", {31'd0, abort_pulse}, 32'd1);
    shifts(7, 1'b1, 8'hC3);
    check("t4_abort_clear", {31'd0, abort_pulse}, 32'd0);
    idle(2, 1'b0);
    check("t4_valid", {31'd0, word_valid}, 32'd1);
    check("t4_data", 32'(word_data), 32'hC3);
    check("t4_dir", {31'd0, word_dir}, 32'd1);
    check("t4_fill", 32'(fill_cnt), 32'd1);
    idle(2, 1'b1);

    // sync_clr after 3 shifts: the next 8 shifts give exactly one word.
    shifts(3, 1'b0, 8'h03);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
    check("t5_no_abort", {31'd0, abort_pulse}, 32'd0);
    shifts(8, 1'b0, 8'h5A);
    idle(3, 1'b0);
    check("t5_fill", 32'(fill_cnt), 32'd1);
    check("t5_data", 32'(word_data), 32'h5A);
    idle(1, 1'b1);
    check("t5_empty", 32'(fill_cnt), 32'd0);
    // sync_clr during the capture cycle cancels the push.
    shifts(8, 1'b0, 8'h77);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0);
    idle(3, 1'b0);
    check("t5_cancel", 32'(fill_cnt), 32'd0);

    // Reset mid-word with one word queued.
    shifts(8, 1'b1, 8'h9C);
    idle(2, 1'b0);
    check("t6_queued", {31'd0, word_valid}, 32'd1);
    shifts(3, 1'b0, 8'h04);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, word_valid}, 32'd0);
    check("t6_rst_fill", 32'(fill_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2, 1'b0);
    check("t6_after", 32'(fill_cnt), 32'd0);

    // Randomized traffic checked by the model every cycle.
    begin
      bit drv;
      drv = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        bit en, clr, rdy;
        en  = ($urandom_range(0, 9) < 8);
        if ($urandom_range(0, 15) == 0) drv = ~drv;
        clr = ($urandom_range(0, 63) == 0);
        rdy = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                   : ($urandom_range(0, 3) != 0);
        cyc(en, drv, clr, rdy, W'($urandom));
      end
    end
    idle(4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
